// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pixel pipeline: pixel width, pixel type,
// frame geometry and the unsigned max helper used by the pooling stages.
package cnn_pkg;

  localparam int WORD_SIZE      = 8;
  localparam int FRAME_ROW_SIZE = 538;
  localparam int FRAME_NUM_ROWS = 538;

  typedef logic [WORD_SIZE-1:0] pixel_t;

  // Unsigned compare at pixel width; on a tie either operand is the answer.
  function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line of partial 2x2 maxima: one write port, one asynchronous
// read port, no reset so it maps onto distributed RAM.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = 269,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  // Top-row pair maxima are captured on even rows only.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster pixel stream. Even rows park the
// horizontal pair maximum in a half-width line buffer; odd rows combine the
// current pair with that entry and emit one registered pooled pixel.
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int WORD_SIZE = cnn_pkg::WORD_SIZE,
  parameter int ROW_SIZE  = cnn_pkg::FRAME_ROW_SIZE,
  parameter int NUM_ROWS  = cnn_pkg::FRAME_NUM_ROWS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_pixel,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_valid,
  output logic                 out_eol,
  output logic                 frame_done
);

  localparam int  HALF     = ROW_SIZE / 2;
  localparam int  CW       = (ROW_SIZE > 2) ? $clog2(ROW_SIZE) : 2;
  localparam int  AW       = CW - 1;
  localparam int  RW       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam bit  HAS_PAIR = (NUM_ROWS >= 2);
  // An odd trailing row never gets a partner, so the frame ends one row early.
  localparam int  LAST_ODD = (NUM_ROWS % 2 == 1) ? NUM_ROWS - 2 : NUM_ROWS - 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(ROW_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(NUM_ROWS - 1);
  localparam logic [RW-1:0] ROW_LAST_ODD = RW'(HAS_PAIR ? LAST_ODD : 0);

  if (ROW_SIZE < 2 || (ROW_SIZE % 2) != 0) begin : g_bad_row_size
    $error("max_pool_2x2: ROW_SIZE must be even and >= 2");
  end
  if (NUM_ROWS < 1) begin : g_bad_num_rows
    $error("max_pool_2x2: NUM_ROWS must be >= 1");
  end
  if (WORD_SIZE != $bits(pixel_t)) begin : g_bad_word_size
    $error("max_pool_2x2: WORD_SIZE must match the pipeline pixel width");
  end

  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row, row_eff;
  logic [AW-1:0] lb_addr;
  pixel_t        pair, pair_max, lb_rdata, win_max;
  logic          lb_we, emit, col_end;

  // A start-of-frame beat is always position (0,0); stale partial windows die here.
  always_comb begin
    col_eff = col;
    row_eff = row;
    if (in_sof) begin
      col_eff = '0;
      row_eff = '0;
    end
  end

  assign col_end  = (col_eff == COL_LAST);
  assign lb_addr  = col_eff[CW-1:1];
  assign pair_max = pix_max(pair, in_pixel);
  assign win_max  = pix_max(pair_max, lb_rdata);
  assign lb_we    = in_valid & col_eff[0] & ~row_eff[0];
  assign emit     = in_valid & col_eff[0] & row_eff[0] & HAS_PAIR;

  pool_line_buffer #(
    .DEPTH (HALF),
    .AW    (AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Raster position; idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col_end) begin
        col <= '0;
        row <= (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  // Left pixel of each horizontal pair waits here for its right neighbour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair <= '0;
    end else if (in_valid && !col_eff[0]) begin
      pair <= in_pixel;
    end
  end

  // Registered pooled output; the pixel holds between emissions, flags pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pixel  <= '0;
      out_valid  <= 1'b0;
      out_eol    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      out_eol    <= emit & col_end;
      frame_done <= emit & col_end & (row_eff == ROW_LAST_ODD);
      if (emit) out_pixel <= win_max;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: a 4x4 instance for the main cases and a
// 4x3 instance for the odd-row-count frame.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_pixel, in_pixel3;
  logic       in_valid, in_sof, in_valid3, in_sof3;
  logic [7:0] out_pixel, out_pixel3;
  logic       out_valid, out_eol, frame_done;
  logic       out_valid3, out_eol3, frame_done3;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_pix  = 8'd0;
  logic [7:0] exp_pix3 = 8'd0;

  logic [7:0] ramp [16];
  logic [7:0] vals [16];
  logic [7:0] zero [16];
  logic [7:0] ex_ramp [4];
  logic [7:0] ex_vals [4];
  logic [7:0] ex_zero [4];

  always #5 clk = ~clk;

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .NUM_ROWS(4)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_eol(out_eol), .frame_done(frame_done)
  );

  max_pool_2x2 #(.WORD_SIZE(8), .ROW_SIZE(4), .NUM_ROWS(3)) dut3 (
    .clk(clk), .rst(rst), .in_pixel(in_pixel3), .in_valid(in_valid3), .in_sof(in_sof3),
    .out_pixel(out_pixel3), .out_valid(out_valid3), .out_eol(out_eol3), .frame_done(frame_done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic v, input logic eol, input logic fd,
                        input logic [7:0] pix);
    if (v) exp_pix = pix;
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".eol"},   32'(out_eol),   32'(eol));
    chk({tag, ".done"},  32'(frame_done), 32'(fd));
    chk({tag, ".pixel"}, 32'(out_pixel), 32'(exp_pix));
  endtask

  task automatic check3(input string tag, input logic v, input logic eol, input logic fd,
                        input logic [7:0] pix);
    if (v) exp_pix3 = pix;
    chk({tag, ".valid"}, 32'(out_valid3), 32'(v));
    chk({tag, ".eol"},   32'(out_eol3),   32'(eol));
    chk({tag, ".done"},  32'(frame_done3), 32'(fd));
    chk({tag, ".pixel"}, 32'(out_pixel3), 32'(exp_pix3));
  endtask

  task automatic cycle4(input logic v, input logic [7:0] p, input logic s);
    @(negedge clk);
    in_valid = v;
    in_pixel = p;
    in_sof   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle3(input logic v, input logic [7:0] p, input logic s);
    @(negedge clk);
    in_valid3 = v;
    in_pixel3 = p;
    in_sof3   = s;
    @(posedge clk);
    #1;
  endtask

  // Drives up to 16 beats of a 4x4 frame; pooled outputs expected after beats 5, 7, 13, 15.
  task automatic run_frame(input logic [7:0] px [16], input logic [7:0] ex [4], input bit sof0,
                           input bit bubbles, input int nbeats, input string tag);
    int k = 0;
    for (int i = 0; i < nbeats; i++) begin
      cycle4(1'b1, px[i], sof0 && (i == 0));
      if (i == 5 || i == 7 || i == 13 || i == 15) begin
        check4($sformatf("%s[%0d]", tag, i), 1'b1, (i == 7 || i == 15), (i == 15), ex[k]);
        k++;
      end else begin
        check4($sformatf("%s[%0d]", tag, i), 1'b0, 1'b0, 1'b0, 8'd0);
      end
      if (bubbles) begin
        cycle4(1'b0, 8'hAA, 1'b1);
        check4($sformatf("%s_gap[%0d]", tag, i), 1'b0, 1'b0, 1'b0, 8'd0);
        if (i == 6) begin
          for (int g = 0; g < 10; g++) begin
            cycle4(1'b0, 8'hFF, 1'b0);
            check4($sformatf("%s_long[%0d]", tag, g), 1'b0, 1'b0, 1'b0, 8'd0);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i] = 8'(i);
      zero[i] = 8'd0;
    end
    vals = '{8'd255, 8'd0,   8'd9, 8'd9,
             8'd0,   8'd0,   8'd9, 8'd9,
             8'd3,   8'd200, 8'd1, 8'd2,
             8'd7,   8'd4,   8'd0, 8'd128};
    ex_ramp = '{8'd5, 8'd7, 8'd13, 8'd15};
    ex_vals = '{8'd255, 8'd9, 8'd200, 8'd128};
    ex_zero = '{8'd0, 8'd0, 8'd0, 8'd0};

    rst = 1'b0;
    in_pixel = 8'd0;  in_valid = 1'b0;  in_sof = 1'b0;
    in_pixel3 = 8'd0; in_valid3 = 1'b0; in_sof3 = 1'b0;
    #12;
    check4("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    check3("reset3", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(ramp, ex_ramp, 1'b1, 1'b0, 16, "ramp");
    run_frame(ramp, ex_ramp, 1'b1, 1'b1, 16, "bubble");
    run_frame(vals, ex_vals, 1'b1, 1'b0, 16, "vals");
    run_frame(zero, ex_zero, 1'b1, 1'b0, 16, "zero");

    run_frame(ramp, ex_ramp, 1'b1, 1'b0, 7, "partial");
    run_frame(ramp, ex_ramp, 1'b1, 1'b0, 16, "resync");

    run_frame(ramp, ex_ramp, 1'b1, 1'b0, 6, "pre_rst");
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_pix  = 8'd0;
    exp_pix3 = 8'd0;
    check4("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check4("rst_held", 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    run_frame(ramp, ex_ramp, 1'b0, 1'b0, 16, "post_rst");

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 12; i++) begin
        cycle3(1'b1, 8'(i), (f == 0) && (i == 0));
        if (i == 5)
          check3($sformatf("odd%0d[%0d]", f, i), 1'b1, 1'b0, 1'b0, 8'd5);
        else if (i == 7)
          check3($sformatf("odd%0d[%0d]", f, i), 1'b1, 1'b1, 1'b1, 8'd7);
        else
          check3($sformatf("odd%0d[%0d]", f, i), 1'b0, 1'b0, 1'b0, 8'd0);
      end
    end
    cycle3(1'b0, 8'd0, 1'b0);
    check3("odd_idle", 1'b0, 1'b0, 1'b0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
